// File: rtl/weapon_pkg.sv
// Weapon-state constants shared with weapon_controller, plus the FX sequencer state encoding.
package weapon_pkg;

   localparam logic [2:0] WPN_LOADED  = 3'b001;
   localparam logic [2:0] WPN_FIRING  = 3'b010;
   localparam logic [2:0] WPN_FIRE_ID = 3'b100;

   typedef enum logic [1:0] {
      FX_IDLE    = 2'd0,
      FX_FIRE    = 2'd1,
      FX_RECOVER = 2'd2
   } fx_state_e;

   // Exact match only, so a non-one-hot bus never counts as Firing.
   function automatic logic is_firing(input logic [2:0] state);
      return state == WPN_FIRING;
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Animation frame timebase: counts while en is high and pulses tick for one cycle on wrap.
module frame_tick_gen #(
   parameter int unsigned TICK_DIV = 1666667
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CntW = $clog2(TICK_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [CntW-1:0] r_cnt;
   logic            w_wrap;

   assign w_wrap = en && (r_cnt == CntMax);
   assign tick   = w_wrap;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (!en || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/weapon_fx_sequencer.sv
// Turns the Firing edge of weapon_state into a shot pulse, sprite animation and muzzle flash.
// Optional ammo tracking is enabled by defining WEAPON_AMMO_EN.
module weapon_fx_sequencer
   import weapon_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 1666667,
   parameter int unsigned NUM_FRAMES   = 4,
   parameter int unsigned FRAME_W      = 2,
   parameter int unsigned FLASH_FRAMES = 2,
   parameter int unsigned AMMO_MAX     = 50
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         weapon_state,
   input  logic               reload,
   output logic [FRAME_W-1:0] sprite_frame,
   output logic               muzzle_flash,
   output logic               shot_pulse,
   output logic               anim_busy,
   output logic [6:0]         ammo_count,
   output logic               ammo_empty
);

   localparam logic [FRAME_W-1:0] LastFrame = FRAME_W'(NUM_FRAMES - 1);
   localparam logic [FRAME_W-1:0] FlashLast = FRAME_W'(FLASH_FRAMES);

   fx_state_e          r_state;
   fx_state_e          w_state_nxt;
   logic [2:0]         r_prev;
   logic [FRAME_W-1:0] r_frame;
   logic [FRAME_W-1:0] w_frame_nxt;
   logic               r_flash;
   logic               w_flash_nxt;
   logic               r_shot;
   logic               w_shot_nxt;
   logic               w_fire_edge;
   logic               w_accept;
   logic               w_tick_en;
   logic               w_tick;
   logic               w_ammo_empty;

   assign w_fire_edge = is_firing(weapon_state) && !is_firing(r_prev);
   assign w_accept    = (r_state == FX_IDLE) && w_fire_edge && !w_ammo_empty;
   assign w_tick_en   = (r_state == FX_FIRE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev <= WPN_LOADED;
      end else begin
         r_prev <= weapon_state;
      end
   end

   frame_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_frame_tick_gen (
      .clk (clk),
      .rst (rst),
      .en  (w_tick_en),
      .tick(w_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= FX_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         FX_IDLE:    if (w_accept) w_state_nxt = FX_FIRE;
         FX_FIRE:    if (w_tick && (r_frame == LastFrame)) w_state_nxt = FX_RECOVER;
         // Holding Firing parks here, so a held trigger never auto-refires.
         FX_RECOVER: if (!is_firing(weapon_state)) w_state_nxt = FX_IDLE;
         default:    w_state_nxt = FX_IDLE;
      endcase
   end

   always_comb begin
      w_frame_nxt = r_frame;
      w_shot_nxt  = 1'b0;
      unique case (r_state)
         FX_IDLE: begin
            if (w_accept) begin
               w_frame_nxt = FRAME_W'(1);
               w_shot_nxt  = 1'b1;
            end
         end
         FX_FIRE: begin
            if (w_tick) begin
               w_frame_nxt = (r_frame == LastFrame) ? '0 : r_frame + 1'b1;
            end
         end
         default: w_frame_nxt = '0;
      endcase
      w_flash_nxt = (w_state_nxt == FX_FIRE) && (w_frame_nxt != '0) && (w_frame_nxt <= FlashLast);
   end

   // Outputs are registered from next-state values so they are glitch-free and cycle-aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame <= '0;
         r_flash <= 1'b0;
         r_shot  <= 1'b0;
      end else begin
         r_frame <= w_frame_nxt;
         r_flash <= w_flash_nxt;
         r_shot  <= w_shot_nxt;
      end
   end

   assign sprite_frame = r_frame;
   assign muzzle_flash = r_flash;
   assign shot_pulse   = r_shot;
   assign anim_busy    = (r_state != FX_IDLE);

`ifdef WEAPON_AMMO_EN
   localparam logic [6:0] AmmoFull = 7'(AMMO_MAX);

   logic [6:0] r_ammo;
   logic [6:0] w_ammo_nxt;

   always_comb begin
      w_ammo_nxt = r_ammo;
      if (reload) begin
         w_ammo_nxt = w_accept ? AmmoFull - 7'd1 : AmmoFull;
      end else if (w_accept && (r_ammo != '0)) begin
         w_ammo_nxt = r_ammo - 7'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ammo <= AmmoFull;
      end else begin
         r_ammo <= w_ammo_nxt;
      end
   end

   assign w_ammo_empty = (r_ammo == '0);
   assign ammo_count   = r_ammo;
`else
   logic w_unused_reload;

   assign w_unused_reload = reload;
   assign w_ammo_empty    = 1'b0;
   assign ammo_count      = 7'd0;
`endif

   assign ammo_empty = w_ammo_empty;

endmodule

// File: tb/tb_weapon_fx_sequencer.sv
// Scoreboard bench for weapon_fx_sequencer; follows WEAPON_AMMO_EN for the ammo expectations.
module tb_weapon_fx_sequencer;
   import weapon_pkg::*;

   localparam int unsigned TICK_DIV     = 4;
   localparam int unsigned NUM_FRAMES   = 4;
   localparam int unsigned FRAME_W      = 2;
   localparam int unsigned FLASH_FRAMES = 2;
   localparam int unsigned AMMO_MAX     = 3;
   localparam int unsigned ANIM_CYC     = TICK_DIV * (NUM_FRAMES - 1);

   typedef struct packed {
      logic [FRAME_W-1:0] frame;
      logic               flash;
      logic               shot;
      logic               busy;
      logic [6:0]         ammo;
      logic               empty;
   } obs_t;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [2:0]         weapon_state = WPN_LOADED;
   logic               reload = 1'b0;
   logic [FRAME_W-1:0] sprite_frame;
   logic               muzzle_flash;
   logic               shot_pulse;
   logic               anim_busy;
   logic [6:0]         ammo_count;
   logic               ammo_empty;
   obs_t               obs;

   int   checks   = 0;
   int   failures = 0;
   int   exp_ammo = 0;
   obs_t exp_q[$];

   weapon_fx_sequencer #(
      .TICK_DIV    (TICK_DIV),
      .NUM_FRAMES  (NUM_FRAMES),
      .FRAME_W     (FRAME_W),
      .FLASH_FRAMES(FLASH_FRAMES),
      .AMMO_MAX    (AMMO_MAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .weapon_state(weapon_state),
      .reload      (reload),
      .sprite_frame(sprite_frame),
      .muzzle_flash(muzzle_flash),
      .shot_pulse  (shot_pulse),
      .anim_busy   (anim_busy),
      .ammo_count  (ammo_count),
      .ammo_empty  (ammo_empty)
   );

   always #5 clk = ~clk;

   assign obs = {sprite_frame, muzzle_flash, shot_pulse, anim_busy, ammo_count, ammo_empty};

   function automatic obs_t mk(input int frame, input bit flash, input bit shot, input bit busy);
      obs_t o;
      o.frame = FRAME_W'(frame);
      o.flash = flash;
      o.shot  = shot;
      o.busy  = busy;
      o.ammo  = 7'(exp_ammo);
`ifdef WEAPON_AMMO_EN
      o.empty = (exp_ammo == 0);
`else
      o.empty = 1'b0;
`endif
      return o;
   endfunction

   task automatic push_exp(input int frame, input bit flash, input bit shot, input bit busy);
      exp_q.push_back(mk(frame, flash, shot, busy));
   endtask

   // One accepted shot: frames 1..NUM_FRAMES-1 for TICK_DIV cycles each, then RECOVER cycles.
   task automatic push_anim(input int recover);
`ifdef WEAPON_AMMO_EN
      if (exp_ammo > 0) exp_ammo--;
`endif
      for (int f = 1; f < int'(NUM_FRAMES); f++) begin
         for (int k = 0; k < int'(TICK_DIV); k++) begin
            push_exp(f, f <= int'(FLASH_FRAMES), (f == 1) && (k == 0), 1'b1);
         end
      end
      repeat (recover) push_exp(0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      obs_t e;
      int   i = 0;
      rst = 1'b0;
      weapon_state = WPN_LOADED;
      reload = 1'b0;
      repeat (2) @(posedge clk);
      #1;
`ifdef WEAPON_AMMO_EN
      exp_ammo = AMMO_MAX;
`else
      exp_ammo = 0;
`endif
      e = mk(0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL reset_hold got=%h want=%h", obs, e);
      end
      rst = 1'b1;
      push_exp(0, 1'b0, 1'b0, 1'b0);
      push_exp(0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL reset_release cyc=%0d got=%h want=%h", i, obs, e);
         end
         i++;
      end
   endtask

   task automatic test_fire();
      obs_t e;
      int   i = 0;
      weapon_state = WPN_FIRING;
      push_anim(1);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL fire cyc=%0d got=%h want=%h", i, obs, e);
         end
         i++;
      end
      weapon_state = WPN_LOADED;
      push_exp(0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL fire_release got=%h want=%h", obs, e);
         end
      end
   endtask

   task automatic test_hold();
      obs_t e;
      int   i = 0;
      weapon_state = WPN_FIRING;
      push_anim(40 - ANIM_CYC);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL hold cyc=%0d got=%h want=%h", i, obs, e);
         end
         i++;
      end
      weapon_state = WPN_LOADED;
      push_exp(0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL hold_release got=%h want=%h", obs, e);
         end
      end
   endtask

   task automatic test_retrigger();
      obs_t e;
      int   i = 1;
      weapon_state = WPN_FIRING;
      push_anim(1);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL retrigger cyc=%0d got=%h want=%h", i, obs, e);
         end
         // Bounce 010->100->010 during frame 2.
         if (i == int'(TICK_DIV) + 1) weapon_state = WPN_FIRE_ID;
         if (i == int'(TICK_DIV) + 2) weapon_state = WPN_FIRING;
         i++;
      end
      weapon_state = WPN_LOADED;
      push_exp(0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL retrigger_release got=%h want=%h", obs, e);
         end
      end
   endtask

   task automatic test_ammo();
      obs_t e;
      int   i = 0;
`ifdef WEAPON_AMMO_EN
      weapon_state = WPN_FIRING;
      repeat (3) push_exp(0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL dry_fire cyc=%0d got=%h want=%h", i, obs, e);
         end
         i++;
      end
      weapon_state = WPN_LOADED;
      reload = 1'b1;
      exp_ammo = AMMO_MAX;
      push_exp(0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         reload = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL reload got=%h want=%h", obs, e);
         end
      end
      // Start the shot from a full magazine so reload+shot must land on AMMO_MAX-1.
      exp_ammo = AMMO_MAX;
`endif
      weapon_state = WPN_FIRING;
      reload = 1'b1;
      push_anim(1);
      i = 0;
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         reload = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL reload_with_shot cyc=%0d got=%h want=%h", i, obs, e);
         end
         i++;
      end
      weapon_state = WPN_LOADED;
      push_exp(0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL ammo_release got=%h want=%h", obs, e);
         end
      end
   endtask

   task automatic test_async_reset();
      obs_t e;
      int   i = 1;
      weapon_state = WPN_FIRING;
      push_anim(1);
      while (i <= int'(TICK_DIV) + 1) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL pre_reset cyc=%0d got=%h want=%h", i, obs, e);
         end
         i++;
      end
      // Mid-cycle, well away from any clock edge.
      #1;
      rst = 1'b0;
      #1;
`ifdef WEAPON_AMMO_EN
      exp_ammo = AMMO_MAX;
`endif
      e = mk(0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL async_reset got=%h want=%h", obs, e);
      end
      exp_q.delete();
      weapon_state = WPN_LOADED;
      @(posedge clk);
      #1;
      rst = 1'b1;
      push_exp(0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL post_reset_idle got=%h want=%h", obs, e);
         end
      end
      weapon_state = WPN_FIRING;
      push_anim(1);
      i = 0;
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL post_reset_fire cyc=%0d got=%h want=%h", i, obs, e);
         end
         i++;
      end
      weapon_state = WPN_LOADED;
      push_exp(0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL post_reset_release got=%h want=%h", obs, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fire();
      test_hold();
      test_retrigger();
      test_ammo();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
